// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage.
// Valid/ready stream with bubble-collapsing stages and optional signed saturation.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int S = WIDTH / STAGES;

  // Returns {carry out, sum} of one slice built from 4-bit lookahead groups.
  function automatic logic [S:0] cla_slice(
    input logic [S-1:0] a,
    input logic [S-1:0] b,
    input logic         ci
  );
    logic [S-1:0] p;
    logic [S-1:0] g;
    logic [S:0]   c;
    logic         gg;
    logic         pp;
    p = a ^ b;
    g = a & b;
    c = '0;
    c[0] = ci;
    for (int j = 0; j < S; j += 4) begin
      c[j+1] = g[j] | (p[j] & c[j]);
      c[j+2] = g[j+1] | (p[j+1] & g[j])
             | (p[j+1] & p[j] & c[j]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1])
             | (p[j+2] & p[j+1] & g[j])
             | (p[j+2] & p[j+1] & p[j] & c[j]);
      gg = g[j+3] | (p[j+3] & g[j+2])
         | (p[j+3] & p[j+2] & g[j+1])
         | (p[j+3] & p[j+2] & p[j+1] & g[j]);
      pp = p[j+3] & p[j+2] & p[j+1] & p[j];
      c[j+4] = gg | (pp & c[j]);
    end
    return {c[S], p ^ c[S-1:0]};
  endfunction

  logic             v_in  [STAGES];
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             t_in  [STAGES];

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             t_q   [STAGES];

  logic             ovf_q;
  logic             zero_q;
  logic [STAGES:0]  rdy;

  // A stage may load when it is empty or everything after it can move.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [S:0]       r;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] s_ld;

    if (k == 0) begin : g_first
      assign v_in[0] = in_valid;
      assign a_in[0] = in_a;
      assign b_in[0] = in_sub ? ~in_b : in_b;
      assign c_in[0] = in_cin ^ in_sub;
      assign t_in[0] = in_sat;
      assign s_in[0] = '0;
    end else begin : g_next
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign t_in[k] = t_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    assign r = cla_slice(a_in[k][k*S +: S],
                         b_in[k][k*S +: S],
                         c_in[k]);

    always_comb begin
      s_nxt = s_in[k];
      s_nxt[k*S +: S] = r[S-1:0];
    end

    if (k == STAGES - 1) begin : g_last
      logic cmsb;
      logic ovf;
      // Carry into the MSB recovered from sum = a ^ b ^ c.
      assign cmsb = r[S-1] ^ a_in[k][WIDTH-1]
                  ^ b_in[k][WIDTH-1];
      assign ovf = cmsb ^ r[S];

      always_comb begin
        s_ld = s_nxt;
        if (t_in[k] && ovf) begin
          s_ld = s_nxt[WIDTH-1]
               ? {1'b0, {(WIDTH-1){1'b1}}}
               : {1'b1, {(WIDTH-1){1'b0}}};
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (rdy[k] && v_in[k]) begin
          ovf_q  <= ovf;
          zero_q <= (s_ld == '0);
        end
      end
    end else begin : g_mid
      assign s_ld = s_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        t_q[k] <= 1'b0;
      end else if (rdy[k]) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_ld;
          c_q[k] <= r[S];
          t_q[k] <= t_in[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: vector table, streaming, stalls,
// bubbles and mid-stream reset, all checked through an output scoreboard.
module tb_pipelined_cla_addsub;

  localparam int W  = 32;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         in_sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .in_sub(in_sub), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_zero(out_zero)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    res_t         exp;
  } vec_t;

  res_t sb[$];
  res_t drv_exp;
  res_t prev_out;
  res_t e;
  bit   prev_hold = 0;
  bit   saw_full = 0;
  int   popped = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic cin,
                                 input logic sub,
                                 input logic sat);
    logic [W:0]   t;
    logic [W-1:0] bb;
    res_t         r;
    bb = sub ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub ^ cin};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    if (sat && r.ovf)
      r.sum = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Scoreboard: push on accept, pop on emit, and watch stalled outputs.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hold)
        check("hold_stable",
              64'({out_valid, out_sum, out_cout, out_ovf, out_zero}),
              64'({1'b1, prev_out}));
      if (in_valid && !in_ready) saw_full = 1;
      if (in_valid && in_ready) sb.push_back(drv_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected none",
                   out_sum);
        end else begin
          e = sb.pop_front();
          check($sformatf("result_%0d", popped),
                64'({out_sum, out_cout, out_ovf, out_zero}),
                64'(e));
          popped++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_sum, out_cout, out_ovf, out_zero};
    end else begin
      prev_hold = 0;
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic sat, input res_t x);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_sat = sat;
    drv_exp = x;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a = 32'hDEAD_BEEF;
    in_b = 32'h1234_5678;
    in_cin = 1'b1;
    in_sub = 1'b1;
    in_sat = 1'b1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub,
                      input logic sat, input res_t x);
    bit done;
    done = 0;
    drive(a, b, cin, sub, sat, x);
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accepting edge to the first visible out_valid.
  task automatic measure(output int lat);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    #1;
  endtask

  task automatic bubble(input string name, input logic [7:0] pat,
                        input logic [7:0] ordy,
                        input logic [7:0] expov);
    logic [7:0] ov;
    ov = '0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (pat[n])
        drive(W'(n * 5), W'(1000 + n), 1'b0, 1'b0, 1'b0,
              model(W'(n * 5), W'(1000 + n), 1'b0, 1'b0, 1'b0));
      else
        idle();
      out_ready = ordy[n];
      @(negedge clk);
      ov[n] = out_valid;
    end
    out_ready = 1'b1;
    idle();
    check(name, 64'(ov), 64'(expov));
    @(posedge clk);
    #1;
  endtask

  vec_t vt[11];
  int   lat;
  int   p0;

  initial begin
    vt[0]  = '{32'h0000_FFFF, 32'h0000_0001, 0, 0, 0,
               '{32'h0001_0000, 1'b0, 1'b0, 1'b0}};
    vt[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0,
               '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    vt[2]  = '{32'd5, 32'd7, 0, 1, 0,
               '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    vt[3]  = '{32'd7, 32'd5, 1, 1, 0,
               '{32'h0000_0001, 1'b1, 1'b0, 1'b0}};
    vt[4]  = '{32'h7FFF_FFFF, 32'd1, 0, 0, 0,
               '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    vt[5]  = '{32'h7FFF_FFFF, 32'd1, 0, 0, 1,
               '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
    vt[6]  = '{32'h8000_0000, 32'd1, 0, 1, 1,
               '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
    vt[7]  = '{32'h1234_5678, 32'h0FED_CBA8, 1, 0, 0,
               '{32'h2222_2221, 1'b0, 1'b0, 1'b0}};
    vt[8]  = '{32'h0, 32'h0, 0, 1, 0,
               '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    vt[9]  = '{32'h8000_0000, 32'h8000_0000, 0, 0, 1,
               '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
    vt[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 1, 0, 0,
               '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};

    reset = 1'b1;
    out_ready = 1'b1;
    idle();
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum",   64'(out_sum),   64'(0));
    check("rst_out_cout",  64'(out_cout),  64'(0));
    check("rst_out_ovf",   64'(out_ovf),   64'(0));
    check("rst_out_zero",  64'(out_zero),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single add across the slice boundary, with latency measured.
    drive(vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, vt[0].sat, vt[0].exp);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    idle();
    measure(lat);
    check("latency_first", 64'(lat), 64'(ST));
    drain();

    // Vector table streamed back to back.
    foreach (vt[i])
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].sat, vt[i].exp);
    idle();
    drain();

    // Six adds with the sink stalled for cycles 3..8.
    saw_full = 0;
    p0 = popped;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(W'(i), W'(i * 256), 1'b0, 1'b0, 1'b0,
               model(W'(i), W'(i * 256), 1'b0, 1'b0, 1'b0));
        idle();
      end
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 3 && c <= 8);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("in_ready_fell", 64'(saw_full), 64'(1));
    check("stream_count", 64'(popped - p0), 64'(6));

    // Bubbles reproduced, then collapsed by a one-cycle stall.
    bubble("bubble_pattern", 8'b0000_0101, 8'hFF, 8'b0001_0100);
    drain();
    bubble("bubble_collapse", 8'b0000_0101, 8'hFB, 8'b0001_1100);
    drain();

    // Reset with two transactions in flight.
    drive(32'd11, 32'd22, 1'b0, 1'b0, 1'b0, model(32'd11, 32'd22, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(32'd33, 32'd44, 1'b0, 1'b0, 1'b0, model(32'd33, 32'd44, 0, 0, 0));
    @(posedge clk);
    #1;
    idle();
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_sum",   64'(out_sum),   64'(0));
    check("mid_rst_out_flags",
          64'({out_cout, out_ovf, out_zero}), 64'(0));
    check("mid_rst_in_ready",  64'(in_ready),  64'(1));
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    drive(32'h7FFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 1'b1,
          model(32'h7FFF_FFF0, 32'h0000_0020, 0, 0, 1));
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    idle();
    measure(lat);
    check("latency_post_reset", 64'(lat), 64'(ST));
    drain();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
